// File: rtl/alu_sequencer_if.sv
// Signal bundle between alu_sequencer, its requester, and the ALU datapath.
// The slave modport is the sequencer's view; master is the environment's view.
interface alu_sequencer_if;
  logic       i_start;
  logic [3:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_ready;

  logic [7:0] o_db;
  logic [7:0] o_sb;
  logic [7:0] o_adl;
  logic       o_db_add;
  logic       o_db_n_add;
  logic       o_adl_add;
  logic       o_0_add;
  logic       o_sb_add;
  logic       o_1_addc;
  logic       o_sums;
  logic       o_ands;
  logic       o_eors;
  logic       o_ors;
  logic       o_srs;
  logic [7:0] i_add;

  logic [7:0] o_result;
  logic       o_n;
  logic       o_z;
  logic       o_done;

  modport slave (
    input  i_start, i_op, i_a, i_b, i_add,
    output o_ready, o_db, o_sb, o_adl,
    output o_db_add, o_db_n_add, o_adl_add, o_0_add, o_sb_add, o_1_addc,
    output o_sums, o_ands, o_eors, o_ors, o_srs,
    output o_result, o_n, o_z, o_done
  );

  modport master (
    output i_start, i_op, i_a, i_b, i_add,
    input  o_ready, o_db, o_sb, o_adl,
    input  o_db_add, o_db_n_add, o_adl_add, o_0_add, o_sb_add, o_1_addc,
    input  o_sums, o_ands, o_eors, o_ors, o_srs,
    input  o_result, o_n, o_z, o_done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control-side sequencer for the 6502 ALU: one or two strobe passes per request,
// carry/negation handled by an explicit +1 second pass. All outputs registered.
module alu_sequencer (
  input  logic           i_clk,
  input  logic           i_reset,
  alu_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_P1, S_C1, S_P2, S_C2} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_AND = 4'd1, OP_OR  = 4'd2, OP_EOR = 4'd3,
    OP_LSR = 4'd4, OP_ASL = 4'd5, OP_INC = 4'd6, OP_DEC = 4'd7,
    OP_SUB = 4'd8, OP_NEG = 4'd9
  } op_t;

  typedef struct packed {
    logic [7:0] db;
    logic [7:0] sb;
    logic [7:0] adl;
    logic       db_add;
    logic       db_n_add;
    logic       adl_add;
    logic       zero_add;
    logic       sb_add;
    logic       sums;
    logic       ands;
    logic       eors;
    logic       ors;
    logic       srs;
  } drive_t;

  state_t     state, next_state;
  op_t        op_q, op_in;
  drive_t     drv_d, drv_q;
  logic [7:0] result_d, result_q;
  logic       done_d, done_q;
  logic       ready_d, ready_q;
  logic       n_q, z_q;

  function automatic logic two_pass(input op_t op);
    return (op == OP_SUB) || (op == OP_NEG);
  endfunction

  assign op_in = op_t'(bus.i_op);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      drv_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
    end else begin
      state <= next_state;
      if (state == S_IDLE && bus.i_start)
        op_q <= op_in;
      drv_q    <= drv_d;
      result_q <= result_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      n_q      <= result_d[7];
      z_q      <= (result_d == 8'h00);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (bus.i_start) next_state = S_P1;
      S_P1:    next_state = S_C1;
      S_C1:    next_state = two_pass(op_q) ? S_P2 : S_IDLE;
      S_P2:    next_state = S_C2;
      S_C2:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    drv_d    = '0;
    done_d   = (state == S_C1 && !two_pass(op_q)) || (state == S_C2);
    result_d = done_d ? bus.i_add : result_q;
    ready_d  = (next_state == S_IDLE);

    unique case (next_state)
      S_P1: begin
        // P1 is only entered from IDLE, so the live request inputs are the operands.
        unique case (op_in)
          OP_ADD, OP_AND, OP_OR, OP_EOR: begin
            drv_d.sb     = bus.i_a;
            drv_d.sb_add = 1'b1;
            drv_d.db     = bus.i_b;
            drv_d.db_add = 1'b1;
            drv_d.sums   = (op_in == OP_ADD);
            drv_d.ands   = (op_in == OP_AND);
            drv_d.ors    = (op_in == OP_OR);
            drv_d.eors   = (op_in == OP_EOR);
          end
          OP_LSR: begin
            drv_d.db     = bus.i_a;
            drv_d.db_add = 1'b1;
            drv_d.srs    = 1'b1;
          end
          OP_ASL: begin
            drv_d.sb     = bus.i_a;
            drv_d.db     = bus.i_a;
            drv_d.sb_add = 1'b1;
            drv_d.db_add = 1'b1;
            drv_d.sums   = 1'b1;
          end
          OP_INC, OP_DEC: begin
            drv_d.sb      = bus.i_a;
            drv_d.sb_add  = 1'b1;
            drv_d.adl     = (op_in == OP_INC) ? 8'h01 : 8'hFF;
            drv_d.adl_add = 1'b1;
            drv_d.sums    = 1'b1;
          end
          OP_SUB: begin
            drv_d.sb       = bus.i_a;
            drv_d.sb_add   = 1'b1;
            drv_d.db       = bus.i_b;
            drv_d.db_n_add = 1'b1;
            drv_d.sums     = 1'b1;
          end
          OP_NEG: begin
            drv_d.zero_add = 1'b1;
            drv_d.db       = bus.i_a;
            drv_d.db_n_add = 1'b1;
            drv_d.sums     = 1'b1;
          end
          default: ;
        endcase
      end
      S_P2: begin
        // T is captured straight into the o_sb register on C1 exit and held through P2.
        drv_d.sb      = bus.i_add;
        drv_d.sb_add  = 1'b1;
        drv_d.adl     = 8'h01;
        drv_d.adl_add = 1'b1;
        drv_d.sums    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_db       = drv_q.db;
  assign bus.o_sb       = drv_q.sb;
  assign bus.o_adl      = drv_q.adl;
  assign bus.o_db_add   = drv_q.db_add;
  assign bus.o_db_n_add = drv_q.db_n_add;
  assign bus.o_adl_add  = drv_q.adl_add;
  assign bus.o_0_add    = drv_q.zero_add;
  assign bus.o_sb_add   = drv_q.sb_add;
  assign bus.o_1_addc   = 1'b0;
  assign bus.o_sums     = drv_q.sums;
  assign bus.o_ands     = drv_q.ands;
  assign bus.o_eors     = drv_q.eors;
  assign bus.o_ors      = drv_q.ors;
  assign bus.o_srs      = drv_q.srs;
  assign bus.o_result   = result_q;
  assign bus.o_n        = n_q;
  assign bus.o_z        = z_q;
  assign bus.o_done     = done_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the strobes, a per-cycle
// reference model of the request/result timeline, directed plus random stimulus.
module tb_alu_sequencer;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  alu_sequencer_if bus();

  alu_sequencer dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural ALU: ADD register loads the selected function of the selected inputs.
  logic       alu_reset_n;
  logic [7:0] alu_add;
  assign alu_reset_n = ~i_reset;
  assign bus.i_add   = alu_add;

  function automatic logic [7:0] alu_eval(
    input logic [7:0] sb, db, adl,
    input logic dba, dbn, adla, za, sba,
    input logic sums, ands, eors, ors, srs);
    logic [7:0] ai, bi;
    ai = za ? 8'h00 : (sba ? sb : 8'h00);
    bi = dba ? db : (dbn ? ~db : (adla ? adl : 8'h00));
    if (sums)      return ai + bi;
    else if (ands) return ai & bi;
    else if (eors) return ai ^ bi;
    else if (ors)  return ai | bi;
    else if (srs)  return bi >> 1;
    else           return 8'h00;
  endfunction

  always @(posedge i_clk or negedge alu_reset_n) begin
    if (!alu_reset_n) alu_add <= 8'h00;
    else alu_add <= alu_eval(bus.o_sb, bus.o_db, bus.o_adl,
                             bus.o_db_add, bus.o_db_n_add, bus.o_adl_add, bus.o_0_add, bus.o_sb_add,
                             bus.o_sums, bus.o_ands, bus.o_eors, bus.o_ors, bus.o_srs);
  end

  logic [34:0] dut_drive;
  assign dut_drive = {bus.o_db, bus.o_sb, bus.o_adl,
                      bus.o_db_add, bus.o_db_n_add, bus.o_adl_add, bus.o_0_add, bus.o_sb_add,
                      bus.o_1_addc, bus.o_sums, bus.o_ands, bus.o_eors, bus.o_ors, bus.o_srs};

  function automatic logic [7:0] ref_result(input logic [3:0] op, input logic [7:0] a, b);
    case (op)
      4'd0: return a + b;
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a ^ b;
      4'd4: return a >> 1;
      4'd5: return a << 1;
      4'd6: return a + 8'd1;
      4'd7: return a - 8'd1;
      4'd8: return a - b;
      4'd9: return 8'd0 - a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_two(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic logic [34:0] exp_drive(input logic [3:0] op, input logic [7:0] a, b, input int pass);
    logic [7:0] db, sb, adl;
    logic dba, dbn, adla, za, sba, sums, ands, eors, ors, srs;
    {db, sb, adl} = '0;
    {dba, dbn, adla, za, sba, sums, ands, eors, ors, srs} = '0;
    if (pass == 1) begin
      case (op)
        4'd0, 4'd1, 4'd2, 4'd3: begin
          sb = a; sba = 1; db = b; dba = 1;
          sums = (op == 4'd0); ands = (op == 4'd1); ors = (op == 4'd2); eors = (op == 4'd3);
        end
        4'd4: begin db = a; dba = 1; srs = 1; end
        4'd5: begin sb = a; db = a; sba = 1; dba = 1; sums = 1; end
        4'd6: begin sb = a; sba = 1; adl = 8'h01; adla = 1; sums = 1; end
        4'd7: begin sb = a; sba = 1; adl = 8'hFF; adla = 1; sums = 1; end
        4'd8: begin sb = a; sba = 1; db = b; dbn = 1; sums = 1; end
        4'd9: begin za = 1; db = a; dbn = 1; sums = 1; end
        default: ;
      endcase
    end else if (pass == 2) begin
      sb = (op == 4'd8) ? 8'(a + ~b) : 8'(~a);
      sba = 1; adl = 8'h01; adla = 1; sums = 1;
    end
    return {db, sb, adl, dba, dbn, adla, za, sba, 1'b0, sums, ands, eors, ors, srs};
  endfunction

  // Reference timeline: cycles remaining until the result, advanced once per rising edge.
  int         m_cnt = 0;
  logic [3:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0;
  logic       m_done = 1'b0;

  initial begin
    int pass;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        m_cnt = 0; m_res = 8'h00; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_res  = ref_result(m_op, m_a, m_b);
            m_done = 1'b1;
          end
        end else if (bus.i_start) begin
          m_op = bus.i_op; m_a = bus.i_a; m_b = bus.i_b;
          m_cnt = is_two(m_op) ? 4 : 2;
        end
      end
      pass = 0;
      if (m_cnt > 0 && m_cnt == (is_two(m_op) ? 4 : 2)) pass = 1;
      else if (m_cnt == 2 && is_two(m_op)) pass = 2;
      chk("ready",  bus.o_ready,  (m_cnt == 0));
      chk("done",   bus.o_done,   m_done);
      chk("result", bus.o_result, m_res);
      chk("n",      bus.o_n,      m_res[7]);
      chk("z",      bus.o_z,      (m_res == 8'h00));
      chk("drive",  dut_drive,    exp_drive(m_op, m_a, m_b, pass));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] a, b);
    int k = 0;
    while (!bus.o_ready && k < 20) begin @(negedge i_clk); k++; end
    chk("issue_ready", bus.o_ready, 1);
    #1;
    bus.i_start = 1'b1; bus.i_op = op; bus.i_a = a; bus.i_b = b;
    @(negedge i_clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_op = 4'($urandom); bus.i_a = 8'($urandom); bus.i_b = 8'($urandom);
  endtask

  task automatic wait_done(input logic [7:0] exp, input int lat, input string name);
    int n = 0;
    do begin @(negedge i_clk); n++; end while (!bus.o_done && n < 12);
    chk({name, "_lat"}, n, lat);
    chk({name, "_res"}, bus.o_result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ndone;
    bus.i_start = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
    @(negedge i_clk);
    chk("reset_ready", bus.o_ready, 1);
    chk("reset_z", bus.o_z, 1);
    chk("reset_result", bus.o_result, 8'h00);
    #1 i_reset = 1'b0;
    @(negedge i_clk);

    issue(4'd0, 8'h3C, 8'h05);
    chk("add_p1_strobes", dut_drive[10:0], 11'b100_0101_0000);
    chk("add_p1_buses", dut_drive[34:11], {8'h05, 8'h3C, 8'h00});
    wait_done(8'h41, 2, "add");
    chk("add_n", bus.o_n, 0);
    chk("add_z", bus.o_z, 0);

    issue(4'd8, 8'h10, 8'h01);
    chk("sub_p1_dbn", bus.o_db_n_add, 1);
    chk("sub_p1_db", bus.o_db, 8'h01);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("sub_p2_sb", bus.o_sb, 8'h0E);
    chk("sub_p2_adl", bus.o_adl, 8'h01);
    wait_done(8'h0F, 2, "sub");

    issue(4'd9, 8'h01, 8'h00);
    wait_done(8'hFF, 4, "neg");
    chk("neg_n", bus.o_n, 1);
    issue(4'd0, 8'hFF, 8'h01);
    wait_done(8'h00, 2, "add_wrap");
    chk("add_wrap_z", bus.o_z, 1);
    issue(4'd4, 8'h81, 8'h00);
    wait_done(8'h40, 2, "lsr");
    issue(4'd7, 8'h00, 8'h00);
    wait_done(8'hFF, 2, "dec");
    issue(4'd5, 8'h81, 8'h00);
    wait_done(8'h02, 2, "asl");
    issue(4'd3, 8'hA5, 8'h0F);
    wait_done(8'hAA, 2, "eor");

    // INC with start held through P1 and C1: the repeat must be ignored.
    @(negedge i_clk);
    #1 bus.i_start = 1'b1; bus.i_op = 4'd6; bus.i_a = 8'h7F; bus.i_b = 8'h00;
    @(negedge i_clk);
    chk("inc_busy_p1", bus.o_ready, 0);
    @(negedge i_clk);
    chk("inc_busy_c1", bus.o_ready, 0);
    #1 bus.i_start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (i == 0) chk("inc_res", bus.o_result, 8'h80);
      ndone += int'(bus.o_done);
    end
    chk("inc_done_count", ndone, 1);

    issue(4'd8, 8'h55, 8'h22);
    @(negedge i_clk);
    @(negedge i_clk);
    #1 i_reset = 1'b1;
    @(negedge i_clk);
    chk("rst_drive", dut_drive, 35'd0);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_result", bus.o_result, 8'h00);
    chk("rst_done", bus.o_done, 0);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    issue(4'd1, 8'hF0, 8'h3C);
    wait_done(8'h30, 2, "and");

    issue(4'hF, 8'h12, 8'h34);
    wait_done(8'h00, 2, "rsv");
    chk("rsv_z", bus.o_z, 1);
    issue(4'd0, 8'h01, 8'h02);
    chk("b2b_accept", bus.o_ready, 0);
    wait_done(8'h03, 2, "b2b");

    for (int c = 0; c < 1500; c++) begin
      @(negedge i_clk);
      #1;
      i_reset     = ($urandom_range(0, 199) == 0);
      bus.i_start = ($urandom_range(0, 2) == 0);
      bus.i_op    = 4'($urandom_range(0, 15));
      bus.i_a     = 8'($urandom);
      bus.i_b     = 8'($urandom);
    end
    @(negedge i_clk);
    #1 i_reset = 1'b0; bus.i_start = 1'b0;
    repeat (6) @(negedge i_clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
